// File: rtl/osd_dbg_pkg.sv
// Shared types and constants for the OSD debug-value scheduler.
`timescale 1ns/1ps
package osd_dbg_pkg;

    localparam int unsigned VAL_W = 14;

    localparam logic [7:0]  ASCII_SPACE = 8'h20;
    localparam logic [7:0]  ASCII_DASH  = 8'h2D;
    localparam logic [7:0]  ASCII_ZERO  = 8'h30;
    localparam logic [13:0] MAX_DEC     = 14'd9999;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_START,
        ST_WAIT,
        ST_WR0,
        ST_WR1,
        ST_WR2,
        ST_WR3
    } state_e;

    // Replace leading '0' digits with spaces; the units digit is always kept.
    function automatic logic [31:0] blank_leading(input logic [31:0] a);
        logic [31:0] r;
        r = a;
        if (r[31:24] == ASCII_ZERO) begin
            r[31:24] = ASCII_SPACE;
            if (r[23:16] == ASCII_ZERO) begin
                r[23:16] = ASCII_SPACE;
                if (r[15:8] == ASCII_ZERO) begin
                    r[15:8] = ASCII_SPACE;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/osd_rr_arbiter.sv
// Combinational round-robin pick: first pending slot at or after ptr_i.
`timescale 1ns/1ps
module osd_rr_arbiter #(
    parameter int unsigned N_SLOTS = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [N_SLOTS-1:0] pend_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               grant_valid_o
);

    function automatic logic [IDX_W-1:0] slot_at(input logic [IDX_W-1:0] base,
                                                 input int unsigned off);
        return IDX_W'((32'(base) + off) % N_SLOTS);
    endfunction

    // Scan farthest-to-nearest so the nearest pending slot overwrites the result.
    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        for (int unsigned k = 0; k < N_SLOTS; k++) begin
            if (pend_i[slot_at(ptr_i, N_SLOTS - 1 - k)]) begin
                grant_o       = slot_at(ptr_i, N_SLOTS - 1 - k);
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/osd_dbg_value_scheduler.sv
// Shares one binary-to-ASCII converter among N_SLOTS debug values and writes 4 chars per value.
// Optional OSD_DBG_ZERO_BLANK_EN: leading zeros are written as spaces.
`timescale 1ns/1ps
module osd_dbg_value_scheduler
    import osd_dbg_pkg::*;
#(
    parameter int unsigned N_SLOTS     = 4,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned SLOT_STRIDE = 16,
    parameter int unsigned TIMEOUT_CYC = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [N_SLOTS-1:0]       req_i,
    input  logic [N_SLOTS*VAL_W-1:0] value_i,
    output logic                     busy_o,
    output logic                     conv_start_o,
    output logic [VAL_W-1:0]         conv_bin_o,
    input  logic [31:0]              conv_ascii_i,
    input  logic                     conv_done_i,
    output logic                     wr_en_o,
    output logic [ADDR_W-1:0]        wr_addr_o,
    output logic [7:0]               wr_data_o,
    output logic                     err_o
);

    localparam int unsigned IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

    state_e             state_q, state_d;
    logic [N_SLOTS-1:0] pend_q, pend_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [VAL_W-1:0]   bin_q, bin_d;
    logic [31:0]        ascii_q, ascii_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               start_q, start_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic [1:0]         wr_k;
    logic [IDX_W-1:0]   arb_gnt;
    logic               arb_valid;
    logic [VAL_W-1:0]   sel_val;

    osd_rr_arbiter #(
        .N_SLOTS (N_SLOTS),
        .IDX_W   (IDX_W)
    ) u_arb (
        .pend_i        (pend_q),
        .ptr_i         (ptr_q),
        .grant_o       (arb_gnt),
        .grant_valid_o (arb_valid)
    );

    always_comb sel_val = value_i[32'(arb_gnt) * VAL_W +: VAL_W];

    // Next-state and registered-output decode.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        bin_d     = bin_q;
        ascii_d   = ascii_q;
        timer_d   = '0;
        err_d     = err_q;
        wr_k      = 2'd0;
        busy_d    = 1'b0;
        start_d   = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;

        unique case (state_q)
            ST_IDLE: begin
                if ((|pend_q) || (|req_i)) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                if (arb_valid) begin
                    gnt_d          = arb_gnt;
                    pend_d[arb_gnt] = 1'b0;
                    ptr_d          = (32'(arb_gnt) == N_SLOTS - 1) ? '0 : arb_gnt + IDX_W'(1);
                    bin_d          = (sel_val > MAX_DEC) ? MAX_DEC : sel_val;
                    state_d        = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                if (conv_done_i) begin
`ifdef OSD_DBG_ZERO_BLANK_EN
                    ascii_d = blank_leading(conv_ascii_i);
`else
                    ascii_d = conv_ascii_i;
`endif
                    state_d = ST_WR0;
                end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    ascii_d = {4{ASCII_DASH}};
                    err_d   = 1'b1;
                    state_d = ST_WR0;
                end
            end
            ST_WR0:  state_d = ST_WR1;
            ST_WR1:  state_d = ST_WR2;
            ST_WR2:  state_d = ST_WR3;
            ST_WR3:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A request arriving in the grant cycle re-arms its own slot.
        pend_d = pend_d | req_i;

        busy_d  = (state_d != ST_IDLE);
        start_d = (state_d == ST_START);
        case (state_d)
            ST_WR0: begin wr_en_d = 1'b1; wr_k = 2'd0; wr_data_d = ascii_d[31:24]; end
            ST_WR1: begin wr_en_d = 1'b1; wr_k = 2'd1; wr_data_d = ascii_d[23:16]; end
            ST_WR2: begin wr_en_d = 1'b1; wr_k = 2'd2; wr_data_d = ascii_d[15:8];  end
            ST_WR3: begin wr_en_d = 1'b1; wr_k = 2'd3; wr_data_d = ascii_d[7:0];   end
            default: ;
        endcase
        if (wr_en_d) begin
            wr_addr_d = ADDR_W'(BASE_ADDR + 32'(gnt_d) * SLOT_STRIDE + 32'(wr_k));
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            pend_q    <= '0;
            ptr_q     <= '0;
            gnt_q     <= '0;
            bin_q     <= '0;
            ascii_q   <= '0;
            timer_q   <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            bin_q     <= bin_d;
            ascii_q   <= ascii_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy_o       = busy_q;
    assign conv_start_o = start_q;
    assign conv_bin_o   = bin_q;
    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign err_o        = err_q;

endmodule
